// File: rtl/pwm_target_decoder_pkg.sv
// Shared definitions for the RC PWM channel decoders: FSM encodings, scaling
// constants and the centre value used as failsafe on the stick channels.
package pwm_target_decoder_pkg;

  typedef enum logic [3:0] {
    WAIT_RISE = 4'b0001,
    MEASURE   = 4'b0010,
    PROCESS   = 4'b0100,
    WAIT_FALL = 4'b1000
  } pwm_state_t;

  localparam int unsigned PWM_BASE_US  = 1000;
  localparam int unsigned PWM_SHIFT    = 2;
  localparam int unsigned REC_VAL_MAX  = 250;
  localparam int unsigned CENTER_VALUE = 125;

endpackage

// File: rtl/pwm_target_decoder_edge_sync.sv
// Two-flop synchroniser plus a previous-value flop for one raw PWM line.
// All flops reset high so a line already high at reset release is not a rise.
module pwm_edge_sync (
  input  logic us_clk,
  input  logic resetn,
  input  logic pwm_in,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= pwm_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/pwm_target_decoder.sv
// Decodes one RC PWM channel (1000-2000 us) into a 0..250 target value with
// pulse validation, clamping and loss-of-signal failsafe. us_clk is 1 MHz.
module pwm_target_decoder
  import pwm_target_decoder_pkg::*;
#(
  parameter int unsigned REC_VAL_BIT_WIDTH = 8,
  parameter int unsigned COUNT_WIDTH       = 16,
  parameter int unsigned MIN_VALID_US      = 800,
  parameter int unsigned MAX_VALID_US      = 2200,
  parameter int unsigned TIMEOUT_US        = 25000,
  parameter int unsigned FAILSAFE_VALUE    = 0
) (
  input  logic                         us_clk,
  input  logic                         resetn,
  input  logic                         pwm_in,
  output logic [REC_VAL_BIT_WIDTH-1:0] value_out,
  output logic                         update_strobe,
  output logic                         signal_lost,
  output logic                         pulse_reject
);

  localparam logic [COUNT_WIDTH-1:0]       MIN_W    = COUNT_WIDTH'(MIN_VALID_US);
  localparam logic [COUNT_WIDTH-1:0]       MAX_W    = COUNT_WIDTH'(MAX_VALID_US);
  localparam logic [COUNT_WIDTH-1:0]       TMO_MAX  = COUNT_WIDTH'(TIMEOUT_US);
  localparam logic [COUNT_WIDTH-1:0]       BASE_W   = COUNT_WIDTH'(PWM_BASE_US);
  localparam logic [COUNT_WIDTH-1:0]       CLAMP_W  = COUNT_WIDTH'(REC_VAL_MAX);
  localparam logic [REC_VAL_BIT_WIDTH-1:0] FS_VALUE = REC_VAL_BIT_WIDTH'(FAILSAFE_VALUE);

  logic line_high;
  logic rise;
  logic fall;

  pwm_edge_sync u_edge_sync (
    .us_clk (us_clk),
    .resetn (resetn),
    .pwm_in (pwm_in),
    .sync   (line_high),
    .rise   (rise),
    .fall   (fall)
  );

  pwm_state_t             state;
  logic [COUNT_WIDTH-1:0] pulse_cnt;
  logic [COUNT_WIDTH-1:0] width_q;
  logic [COUNT_WIDTH-1:0] tmo_cnt;
  logic [COUNT_WIDTH-1:0] tmo_next;

  logic                         pulse_ok;
  logic [COUNT_WIDTH-1:0]       scaled;
  logic [REC_VAL_BIT_WIDTH-1:0] value_next;

  assign tmo_next = tmo_cnt + COUNT_WIDTH'(1);
  assign pulse_ok = (state == PROCESS) && (width_q >= MIN_W) && (width_q <= MAX_W);

  // Scale in full counter width and clamp before truncating to the output width.
  always_comb begin
    scaled     = '0;
    value_next = '0;
    if (width_q >= BASE_W) begin
      scaled = (width_q - BASE_W) >> PWM_SHIFT;
    end
    if (scaled > CLAMP_W) begin
      scaled = CLAMP_W;
    end
    value_next = scaled[REC_VAL_BIT_WIDTH-1:0];
  end

  always_ff @(posedge us_clk or negedge resetn) begin
    if (!resetn) begin
      state         <= WAIT_RISE;
      pulse_cnt     <= '0;
      width_q       <= '0;
      tmo_cnt       <= '0;
      value_out     <= FS_VALUE;
      signal_lost   <= 1'b1;
      update_strobe <= 1'b0;
      pulse_reject  <= 1'b0;
    end else begin
      update_strobe <= 1'b0;
      pulse_reject  <= 1'b0;

      // An accepted pulse in PROCESS overrides a same-cycle expiry below.
      if (pulse_ok) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt != TMO_MAX) begin
        tmo_cnt <= tmo_next;
        if (tmo_next == TMO_MAX) begin
          signal_lost   <= 1'b1;
          value_out     <= FS_VALUE;
          update_strobe <= 1'b1;
        end
      end

      unique case (state)
        WAIT_RISE: begin
          // The rise cycle already holds one high sample, so counting starts at 1.
          if (rise) begin
            pulse_cnt <= COUNT_WIDTH'(1);
            state     <= MEASURE;
          end
        end
        MEASURE: begin
          if (fall) begin
            width_q <= pulse_cnt;
            state   <= PROCESS;
          end else if (line_high && (pulse_cnt >= MAX_W)) begin
            pulse_reject <= 1'b1;
            state        <= WAIT_FALL;
          end else begin
            pulse_cnt <= pulse_cnt + COUNT_WIDTH'(1);
          end
        end
        PROCESS: begin
          if (pulse_ok) begin
            value_out     <= value_next;
            update_strobe <= 1'b1;
            signal_lost   <= 1'b0;
          end else begin
            pulse_reject <= 1'b1;
          end
          state <= WAIT_RISE;
        end
        WAIT_FALL: begin
          if (fall) begin
            state <= WAIT_RISE;
          end
        end
        default: state <= WAIT_RISE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_target_decoder.sv
// Directed bench for pwm_target_decoder with FAILSAFE_VALUE = 0.
module tb_pwm_target_decoder;

  logic       us_clk = 1'b0;
  logic       resetn = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] value_out;
  logic       update_strobe;
  logic       signal_lost;
  logic       pulse_reject;

  int checks = 0;
  int passed = 0;
  int strobe_cnt = 0;
  int reject_cnt = 0;

  pwm_target_decoder dut (
    .us_clk        (us_clk),
    .resetn        (resetn),
    .pwm_in        (pwm_in),
    .value_out     (value_out),
    .update_strobe (update_strobe),
    .signal_lost   (signal_lost),
    .pulse_reject  (pulse_reject)
  );

  always #5 us_clk = ~us_clk;

  always @(negedge us_clk) begin
    if (update_strobe) strobe_cnt = strobe_cnt + 1;
    if (pulse_reject)  reject_cnt = reject_cnt + 1;
  end

  task automatic tick();
    @(posedge us_clk);
    #1;
  endtask

  // Line is sampled high at exactly w edges; the next edge samples it low.
  task automatic drive_pulse(input int w);
    tick();
    pwm_in = 1'b1;
    repeat (w) tick();
    pwm_in = 1'b0;
  endtask

  task automatic test_reset();
    pwm_in = 1'b0;
    resetn = 1'b0;
    repeat (3) tick();
    checks++; if (value_out !== 8'd0) $display("FAIL reset_value got %0d want 0", value_out); else passed++;
    checks++; if (signal_lost !== 1'b1) $display("FAIL reset_lost got %b want 1", signal_lost); else passed++;
    checks++; if (update_strobe !== 1'b0) $display("FAIL reset_strobe got %b want 0", update_strobe); else passed++;
    checks++; if (pulse_reject !== 1'b0) $display("FAIL reset_reject got %b want 0", pulse_reject); else passed++;
    resetn = 1'b1;
    repeat (10) tick();
  endtask

  task automatic test_basic();
    int s0;
    s0 = strobe_cnt;
    checks++; if (signal_lost !== 1'b1) $display("FAIL basic_lost_before got %b want 1", signal_lost); else passed++;
    drive_pulse(1500);
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (update_strobe !== (i == 4)) $display("FAIL basic_strobe_k%0d got %b want %b", i - 1, update_strobe, (i == 4));
      else passed++;
      if (i == 4) begin
        checks++; if (value_out !== 8'd125) $display("FAIL basic_value got %0d want 125", value_out); else passed++;
        checks++; if (signal_lost !== 1'b0) $display("FAIL basic_lost_after got %b want 0", signal_lost); else passed++;
      end
    end
    checks++; if (strobe_cnt - s0 !== 1) $display("FAIL basic_strobe_count got %0d want 1", strobe_cnt - s0); else passed++;
    repeat (10) tick();
  endtask

  task automatic test_values();
    int w_tab [6] = '{1000, 1004, 2000, 2100, 800, 2200};
    int v_tab [6] = '{0, 1, 250, 250, 0, 250};
    int s0;
    for (int i = 0; i < 6; i++) begin
      s0 = strobe_cnt;
      drive_pulse(w_tab[i]);
      repeat (8) tick();
      checks++;
      if (value_out !== v_tab[i][7:0]) $display("FAIL value_w%0d got %0d want %0d", w_tab[i], value_out, v_tab[i]);
      else passed++;
      checks++;
      if (strobe_cnt - s0 !== 1) $display("FAIL strobes_w%0d got %0d want 1", w_tab[i], strobe_cnt - s0);
      else passed++;
    end
  endtask

  task automatic test_reject();
    int s0, r0, found;
    drive_pulse(1500);
    repeat (8) tick();
    checks++; if (value_out !== 8'd125) $display("FAIL rej_setup_value got %0d want 125", value_out); else passed++;
    s0 = strobe_cnt;
    r0 = reject_cnt;
    drive_pulse(700);
    repeat (8) tick();
    checks++; if (reject_cnt - r0 !== 1) $display("FAIL rej_700_count got %0d want 1", reject_cnt - r0); else passed++;
    drive_pulse(799);
    repeat (8) tick();
    checks++; if (reject_cnt - r0 !== 2) $display("FAIL rej_799_count got %0d want 2", reject_cnt - r0); else passed++;
    // Held high: reject expected at the edge that sees the 2201st high sample.
    tick();
    pwm_in = 1'b1;
    found = 0;
    for (int n = 1; n <= 2210; n++) begin
      tick();
      if (found == 0 && pulse_reject) found = n;
    end
    checks++; if (found !== 2203) $display("FAIL rej_long_edge got %0d want 2203", found); else passed++;
    repeat (790) tick();
    pwm_in = 1'b0;
    repeat (10) tick();
    checks++; if (reject_cnt - r0 !== 3) $display("FAIL rej_total got %0d want 3", reject_cnt - r0); else passed++;
    checks++; if (strobe_cnt - s0 !== 0) $display("FAIL rej_strobes got %0d want 0", strobe_cnt - s0); else passed++;
    checks++; if (value_out !== 8'd125) $display("FAIL rej_value_hold got %0d want 125", value_out); else passed++;
  endtask

  task automatic test_timeout();
    int got, s0;
    drive_pulse(1500);
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      tick();
      if (update_strobe) got = 1;
    end
    checks++; if (got !== 1) $display("FAIL tmo_accept_strobe got %0d want 1", got); else passed++;
    repeat (24999) tick();
    checks++; if (signal_lost !== 1'b0) $display("FAIL tmo_early_lost got %b want 0", signal_lost); else passed++;
    s0 = strobe_cnt;
    tick();
    checks++; if (signal_lost !== 1'b1) $display("FAIL tmo_lost got %b want 1", signal_lost); else passed++;
    checks++; if (update_strobe !== 1'b1) $display("FAIL tmo_strobe got %b want 1", update_strobe); else passed++;
    checks++; if (value_out !== 8'd0) $display("FAIL tmo_value got %0d want 0", value_out); else passed++;
    repeat (200) tick();
    checks++; if (strobe_cnt - s0 !== 1) $display("FAIL tmo_strobe_count got %0d want 1", strobe_cnt - s0); else passed++;
    drive_pulse(1200);
    repeat (8) tick();
    checks++; if (value_out !== 8'd50) $display("FAIL tmo_recover_value got %0d want 50", value_out); else passed++;
    checks++; if (signal_lost !== 1'b0) $display("FAIL tmo_recover_lost got %b want 0", signal_lost); else passed++;
  endtask

  task automatic test_high_at_reset();
    int s0, r0;
    pwm_in = 1'b1;
    resetn = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    s0 = strobe_cnt;
    r0 = reject_cnt;
    repeat (500) tick();
    pwm_in = 1'b0;
    repeat (20) tick();
    checks++; if (strobe_cnt - s0 !== 0) $display("FAIL har_partial_strobes got %0d want 0", strobe_cnt - s0); else passed++;
    checks++; if (reject_cnt - r0 !== 0) $display("FAIL har_partial_rejects got %0d want 0", reject_cnt - r0); else passed++;
    checks++; if (signal_lost !== 1'b1) $display("FAIL har_lost got %b want 1", signal_lost); else passed++;
    drive_pulse(1600);
    repeat (8) tick();
    checks++; if (value_out !== 8'd150) $display("FAIL har_value got %0d want 150", value_out); else passed++;
    checks++; if (strobe_cnt - s0 !== 1) $display("FAIL har_strobes got %0d want 1", strobe_cnt - s0); else passed++;
  endtask

  task automatic test_reset_mid_pulse();
    int s0, r0;
    drive_pulse(1500);
    repeat (8) tick();
    checks++; if (value_out !== 8'd125) $display("FAIL rmp_setup_value got %0d want 125", value_out); else passed++;
    tick();
    pwm_in = 1'b1;
    repeat (900) tick();
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (value_out !== 8'd0) $display("FAIL rmp_value got %0d want 0", value_out); else passed++;
    checks++; if (signal_lost !== 1'b1) $display("FAIL rmp_lost got %b want 1", signal_lost); else passed++;
    checks++; if (update_strobe !== 1'b0) $display("FAIL rmp_strobe got %b want 0", update_strobe); else passed++;
    s0 = strobe_cnt;
    r0 = reject_cnt;
    repeat (3) tick();
    resetn = 1'b1;
    repeat (897) tick();
    pwm_in = 1'b0;
    repeat (20) tick();
    checks++; if (strobe_cnt - s0 !== 0) $display("FAIL rmp_release_strobes got %0d want 0", strobe_cnt - s0); else passed++;
    checks++; if (reject_cnt - r0 !== 0) $display("FAIL rmp_release_rejects got %0d want 0", reject_cnt - r0); else passed++;
    drive_pulse(1404);
    repeat (8) tick();
    checks++; if (value_out !== 8'd101) $display("FAIL rmp_new_value got %0d want 101", value_out); else passed++;
    checks++; if (strobe_cnt - s0 !== 1) $display("FAIL rmp_new_strobes got %0d want 1", strobe_cnt - s0); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_reject();
    test_timeout();
    test_high_at_reset();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/pwm_target_decoder.md
Name: pwm_target_decoder

Overview:
- Decodes one RC receiver PWM channel (1000–2000 us pulses, one per ~20 ms frame) into the 8-bit 0–250 target value that the angle controller consumes as throttle_target, yaw_target, pitch_target or roll_target.
- The top level instantiates one copy per channel.
- Adds input synchronisation, pulse validation, range clamping and loss-of-signal failsafe.
- Runs on us_clk (1 MHz, so 1 cycle = 1 us).

Parameters:
- REC_VAL_BIT_WIDTH, 8: width of value_out.
- COUNT_WIDTH, 16: width of pulse and timeout counters.
- MIN_VALID_US, 800: shortest accepted pulse in us.
- MAX_VALID_US, 2200: longest accepted pulse in us.
- TIMEOUT_US, 25000: us without an accepted pulse before signal_lost.
- FAILSAFE_VALUE, 0: value_out at reset and on signal loss (top uses 0 for throttle, 125 for yaw/pitch/roll).

Ports:
- us_clk  in  1  system clock, 1 MHz.
- resetn  in  1  asynchronous active-low reset.
- pwm_in  in  1  raw asynchronous receiver PWM line.
- value_out  out  REC_VAL_BIT_WIDTH  decoded target, 0..250.
- update_strobe  out  1  one-cycle pulse each time value_out is written.
- signal_lost  out  1  high while in failsafe.
- pulse_reject  out  1  one-cycle pulse when a pulse is discarded.

Behaviour:
- Clock and reset: one clock, us_clk. Reset resetn is asynchronous and active-low.
- Reset values:
  - value_out = FAILSAFE_VALUE, signal_lost = 1, update_strobe = 0, pulse_reject = 0.
  - FSM in WAIT_RISE, counters = 0.
  - Synchroniser flops reset to 1, so a line already high at reset release is not taken as a rising edge. The first pulse is measured only after a full low→high transition.
- Input path: 2-flop synchroniser, then a registered previous-value flop. rise = sync & ~prev; fall = ~sync & prev.
- Measured width W = number of us_clk edges at which pwm_in was sampled high for that pulse.
- FSM states (one-hot): WAIT_RISE, MEASURE, PROCESS, WAIT_FALL.
  - WAIT_RISE: on rise, clear pulse counter and go to MEASURE. fall is ignored here.
  - MEASURE: pulse counter increments each cycle.
    - On fall, latch W and go to PROCESS.
    - If the counter would exceed MAX_VALID_US while the line is still high, pulse pulse_reject for one cycle and go to WAIT_FALL.
  - PROCESS (1 cycle):
    - If W < MIN_VALID_US or W > MAX_VALID_US: pulse_reject = 1, value_out unchanged.
    - Otherwise value_out = min(250, W < 1000 ? 0 : (W-1000)>>2), update_strobe = 1, signal_lost = 0, timeout counter cleared.
    - Always returns to WAIT_RISE.
  - WAIT_FALL: on fall, go to WAIT_RISE. No output change.
- Latency: edge k is the first us_clk edge sampling pwm_in low after a pulse. value_out and update_strobe are registered at edge k+3, and update_strobe is high for exactly that one cycle.
- Timeout:
  - A counter increments every cycle and is cleared on each accepted pulse. It saturates at TIMEOUT_US.
  - In the cycle it reaches TIMEOUT_US: signal_lost = 1, value_out = FAILSAFE_VALUE, update_strobe pulses once.
  - No further strobes until the next accepted pulse.
- Simultaneous events: if an accepted pulse and timeout expiry land on the same cycle, the accepted pulse wins (no failsafe).
- Glitches: a low gap shorter than 2 cycles between pulses may lose the following rise. That pulse is then dropped without pulse_reject. This is accepted behaviour.
- Width rules: arithmetic is unsigned. (W-1000)>>2 is computed in COUNT_WIDTH, then clamped before truncation to REC_VAL_BIT_WIDTH.
- Reset mid-pulse: all state returns to reset values immediately. The partial pulse is discarded.

Decomposition:
- Shared package holds:
  - one-hot state encodings;
  - PWM_BASE_US = 1000, PWM_SHIFT = 2, REC_VAL_MAX = 250;
  - center value 125, used as FAILSAFE_VALUE for the yaw, pitch and roll channels.
- One natural sub-module, pwm_edge_sync: 2-flop synchroniser plus prev flop. Reset value 1; outputs sync, rise, fall.

Test Plan:
- After reset, apply 1500 us high then low -> update_strobe once at edge k+3, value_out = 125, signal_lost falls 1→0.
- Pulses of 1000, 1004, 2000 and 2100 us -> value_out 0, 1, 250, 250 (clamped), each with one update_strobe.
- 700 us pulse, then a line held high 3000 us -> pulse_reject pulses once for each (the second at count MAX_VALID_US+1), value_out holds its prior 125, no update_strobe.
- Accepted pulse then line idle low 25000 us -> signal_lost = 1, value_out = FAILSAFE_VALUE, exactly one update_strobe. A following 1200 us pulse gives value_out = 50 and signal_lost = 0.
- Hold pwm_in high through reset release, fall, then a 1600 us pulse -> first partial pulse ignored with no strobe and no reject; second gives value_out = 150.
- Assert resetn low midway through a 1800 us pulse -> outputs return to reset values immediately, no strobe after release until a new complete pulse arrives.
